i2c_slave_responder: RTL and testbench

- Synthesizable I2C slave register target that sits directly downstream of the iicmb_m_wb multi-bus controller.
- Attaches to one bus of the controller's wired-AND scl/sda pair.
- Lets system-level benches and FPGA builds check the controller against real RTL, not the i2c_if BFM.
- Holds a small byte-addressable register file and supports write-pointer, burst-write and burst-read transfers, including repeated START.

---
 rtl/i2c_slave_responder.sv | 217 +++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_responder.sv
// ============================================================================
// i2c_slave_responder : I2C slave register target (pointer/burst write/read)
// Rev 1.0
// ============================================================================
`default_nettype none

module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h22,
  parameter int         MEM_DEPTH  = 16,
  localparam int        PTR_W      = $clog2(MEM_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             scl_o,
  output logic             sda_o,
  output logic             wr_valid_o,
  output logic [PTR_W-1:0] wr_addr_o,
  output logic [7:0]       wr_data_o,
  output logic             busy_o,
  output logic             sel_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ADDR     = 4'd1,
    S_ADDR_ACK = 4'd2,
    S_IGNORE   = 4'd3,
    S_PTR      = 4'd4,
    S_PTR_ACK  = 4'd5,
    S_WR_BYTE  = 4'd6,
    S_WR_ACK   = 4'd7,
    S_RD_BYTE  = 4'd8,
    S_RD_ACK   = 4'd9
  } state_t;

  state_t           state_q;
  logic             scl_meta_q, scl_sync_q, scl_prev_q;
  logic             sda_meta_q, sda_sync_q, sda_prev_q;
  logic [7:0]       shift_q;
  logic [3:0]       bit_cnt_q;
  logic [PTR_W-1:0] ptr_q;
  logic             rw_q;
  logic             ack_on_q;
  logic             sda_q;
  logic             wr_valid_q;
  logic [PTR_W-1:0] wr_addr_q;
  logic [7:0]       wr_data_q;
  logic             busy_q;
  logic             sel_q;
  logic [7:0]       mem_q [MEM_DEPTH];

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte, rd_byte;

  assign scl_rise  = scl_sync_q & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q & scl_prev_q;
  assign start_det = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
  assign rx_byte   = {shift_q[6:0], sda_sync_q};
  assign rd_byte   = mem_q[ptr_q];

  assign scl_o      = 1'b1;
  assign sda_o      = sda_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = busy_q;
  assign sel_o      = sel_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 4'd0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      ack_on_q   <= 1'b0;
      sda_q      <= 1'b1;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      sel_q      <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
      wr_valid_q <= 1'b0;

      // Bus conditions override any data edge seen in the same cycle.
      if (start_det) begin
        state_q   <= S_ADDR;
        busy_q    <= 1'b1;
        sel_q     <= 1'b0;
        bit_cnt_q <= 4'd0;
        ack_on_q  <= 1'b0;
        sda_q     <= 1'b1;
      end else if (stop_det) begin
        state_q  <= S_IDLE;
        busy_q   <= 1'b0;
        sel_q    <= 1'b0;
        ack_on_q <= 1'b0;
        sda_q    <= 1'b1;
      end else begin
        case (state_q)
          S_ADDR: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd0;
                if (shift_q[6:0] == SLAVE_ADDR) begin
                  sel_q   <= 1'b1;
                  rw_q    <= sda_sync_q;
                  state_q <= S_ADDR_ACK;
                end else begin
                  state_q <= S_IGNORE;
                end
              end
            end
          end

          S_PTR, S_WR_BYTE: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd0;
                if (state_q == S_PTR) begin
                  ptr_q   <= rx_byte[PTR_W-1:0];
                  state_q <= S_PTR_ACK;
                end else begin
                  mem_q[ptr_q] <= rx_byte;
                  wr_valid_q   <= 1'b1;
                  wr_addr_q    <= ptr_q;
                  wr_data_q    <= rx_byte;
                  ptr_q        <= ptr_q + PTR_W'(1);
                  state_q      <= S_WR_ACK;
                end
              end
            end
          end

          // First fall pulls sda low for the ACK slot, second fall ends it.
          S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
            if (scl_fall) begin
              if (!ack_on_q) begin
                sda_q    <= 1'b0;
                ack_on_q <= 1'b1;
              end else begin
                ack_on_q  <= 1'b0;
                bit_cnt_q <= 4'd0;
                sda_q     <= 1'b1;
                if (state_q == S_ADDR_ACK && rw_q) begin
                  shift_q   <= rd_byte;
                  sda_q     <= rd_byte[7];
                  bit_cnt_q <= 4'd1;
                  state_q   <= S_RD_BYTE;
                end else if (state_q == S_ADDR_ACK) begin
                  state_q <= S_PTR;
                end else begin
                  state_q <= S_WR_BYTE;
                end
              end
            end
          end

          S_RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd0) begin
                shift_q   <= rd_byte;
                sda_q     <= rd_byte[7];
                bit_cnt_q <= 4'd1;
              end else if (bit_cnt_q < 4'd8) begin
                shift_q   <= {shift_q[6:0], 1'b0};
                sda_q     <= shift_q[6];
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end else begin
                sda_q   <= 1'b1;
                ptr_q   <= ptr_q + PTR_W'(1);
                state_q <= S_RD_ACK;
              end
            end
          end

          S_RD_ACK: begin
            if (scl_rise) begin
              bit_cnt_q <= 4'd0;
              state_q   <= sda_sync_q ? S_IGNORE : S_RD_BYTE;
            end
          end

          default: begin
            sda_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_responder.sv
// ============================================================================
// tb_i2c_slave_responder : bus-level master model with write scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_i2c_slave_responder;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       scl_bus, sda_bus;
  logic       scl_o, sda_o, wr_valid_o, busy_o, sel_o;
  logic [3:0] wr_addr_o;
  logic [7:0] wr_data_o;

  int          checks = 0;
  int          errors = 0;
  int          sel_rises = 0;
  logic        sel_prev = 1'b0;
  logic [15:0] exp_wr[$];

  assign scl_bus = m_scl & scl_o;
  assign sda_bus = m_sda & sda_o;

  always #5 clk = ~clk;

  i2c_slave_responder #(.SLAVE_ADDR(7'h22), .MEM_DEPTH(16)) dut (
    .clk_i(clk), .rst_i(rst_n), .scl_i(scl_bus), .sda_i(sda_bus),
    .scl_o(scl_o), .sda_o(sda_o), .wr_valid_o(wr_valid_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o), .sel_o(sel_o)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic q_wait();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic wbit(input logic b);
    m_sda = b; q_wait();
    m_scl = 1'b1; q_wait(); q_wait();
    m_scl = 1'b0; q_wait();
  endtask

  task automatic rbit(output logic b);
    m_sda = 1'b1; q_wait();
    m_scl = 1'b1; q_wait();
    b = sda_bus; q_wait();
    m_scl = 1'b0; q_wait();
  endtask

  task automatic start_c();
    m_sda = 1'b1; q_wait();
    m_scl = 1'b1; q_wait();
    m_sda = 1'b0; q_wait();
    m_scl = 1'b0; q_wait();
  endtask

  task automatic stop_c();
    m_sda = 1'b0; q_wait();
    m_scl = 1'b1; q_wait();
    m_sda = 1'b1; q_wait(); q_wait();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic wbyte_chk(input string nm, input logic [7:0] d, input logic exp_ack);
    logic a;
    wbyte(d, a);
    chk(nm, int'(a), int'(exp_ack));
  endtask

  task automatic rbyte_chk(input string nm, input logic master_ack, input logic [7:0] exp);
    logic       b;
    logic [7:0] d;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(master_ack);
    chk(nm, int'(d), int'(exp));
  endtask

  initial begin
    fork
      begin : stim
        logic b;
        logic found;
        int   sel_before;

        repeat (4) @(negedge clk);
        chk("rst_sda_o", int'(sda_o), 1);
        chk("rst_scl_o", int'(scl_o), 1);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_sel", int'(sel_o), 0);
        chk("rst_wr_valid", int'(wr_valid_o), 0);
        chk("rst_wr_addr_data", int'({wr_addr_o, wr_data_o}), 0);
        rst_n = 1'b1;
        q_wait();

        // 1: pointer 3, burst write A5, 5A
        exp_wr.push_back({8'h03, 8'hA5});
        exp_wr.push_back({8'h04, 8'h5A});
        start_c();
        chk("t1_busy_after_start", int'(busy_o), 1);
        wbyte_chk("t1_addr_ack", 8'h44, 1'b0);
        chk("t1_sel", int'(sel_o), 1);
        wbyte_chk("t1_ptr_ack", 8'h03, 1'b0);
        wbyte_chk("t1_d0_ack", 8'hA5, 1'b0);
        wbyte_chk("t1_d1_ack", 8'h5A, 1'b0);
        stop_c();
        chk("t1_busy_after_stop", int'(busy_o), 0);
        chk("t1_sel_after_stop", int'(sel_o), 0);
        chk("t1_wr_pending", exp_wr.size(), 0);

        // 2: read back through repeated START
        start_c();
        wbyte_chk("t2_addr_ack", 8'h44, 1'b0);
        wbyte_chk("t2_ptr_ack", 8'h03, 1'b0);
        start_c();
        chk("t2_sel_cleared_by_rstart", int'(sel_o), 0);
        wbyte_chk("t2_raddr_ack", 8'h45, 1'b0);
        rbyte_chk("t2_rd0", 1'b0, 8'hA5);
        rbyte_chk("t2_rd1", 1'b1, 8'h5A);
        chk("t2_sda_released_after_nack", int'(sda_o), 1);
        stop_c();
        start_c();
        wbyte_chk("t2_raddr2_ack", 8'h45, 1'b0);
        rbyte_chk("t2_rd_ptr5", 1'b1, 8'h00);
        stop_c();

        // 3: address mismatch
        sel_before = sel_rises;
        start_c();
        wbyte_chk("t3_addr_nack", 8'h46, 1'b1);
        wbyte_chk("t3_data_nack", 8'h11, 1'b1);
        stop_c();
        chk("t3_sel_rises", sel_rises - sel_before, 0);

        // 4: pointer wrap 15 -> 0
        exp_wr.push_back({8'h0F, 8'h11});
        exp_wr.push_back({8'h00, 8'h22});
        start_c();
        wbyte_chk("t4_addr_ack", 8'h44, 1'b0);
        wbyte_chk("t4_ptr_ack", 8'h0F, 1'b0);
        wbyte_chk("t4_d0_ack", 8'h11, 1'b0);
        wbyte_chk("t4_d1_ack", 8'h22, 1'b0);
        stop_c();
        start_c();
        wbyte_chk("t4_waddr", 8'h44, 1'b0);
        wbyte_chk("t4_wptr", 8'h0F, 1'b0);
        start_c();
        wbyte_chk("t4_raddr", 8'h45, 1'b0);
        rbyte_chk("t4_rd15", 1'b0, 8'h11);
        rbyte_chk("t4_rd0", 1'b1, 8'h22);
        stop_c();

        // 5a: STOP after 4 data bits discards the partial byte
        start_c();
        wbyte_chk("t5a_addr", 8'h44, 1'b0);
        wbyte_chk("t5a_ptr", 8'h07, 1'b0);
        for (int i = 0; i < 4; i++) wbit(1'b1);
        stop_c();
        chk("t5a_busy", int'(busy_o), 0);
        start_c();
        wbyte_chk("t5a_raddr", 8'h45, 1'b0);
        rbyte_chk("t5a_rd7", 1'b1, 8'h00);
        stop_c();

        // 5b: reset while the slave drives a 0 bit of 0xA5
        start_c();
        wbyte_chk("t5b_addr", 8'h44, 1'b0);
        wbyte_chk("t5b_ptr", 8'h03, 1'b0);
        start_c();
        wbyte_chk("t5b_raddr", 8'h45, 1'b0);
        rbit(b);
        chk("t5b_msb", int'(b), 1);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (sda_o == 1'b0) begin
            found = 1'b1;
            break;
          end
        end
        chk("t5b_drive_zero_seen", int'(found), 1);
        rst_n = 1'b0;
        #1;
        chk("t5b_sda_on_reset", int'(sda_o), 1);
        repeat (3) @(negedge clk);
        chk("t5b_busy_on_reset", int'(busy_o), 0);
        m_sda = 1'b1; q_wait();
        m_scl = 1'b1; q_wait();
        rst_n = 1'b1; q_wait();
        start_c();
        wbyte_chk("t5b_addr2", 8'h44, 1'b0);
        wbyte_chk("t5b_ptr2", 8'h03, 1'b0);
        start_c();
        wbyte_chk("t5b_raddr2", 8'h45, 1'b0);
        rbyte_chk("t5b_rd3_cleared", 1'b1, 8'h00);
        stop_c();
        start_c();
        wbyte_chk("t5b_addr3", 8'h44, 1'b0);
        wbyte_chk("t5b_ptr3", 8'h0F, 1'b0);
        start_c();
        wbyte_chk("t5b_raddr3", 8'h45, 1'b0);
        rbyte_chk("t5b_rd15_cleared", 1'b0, 8'h00);
        rbyte_chk("t5b_rd0_cleared", 1'b1, 8'h00);
        stop_c();

        // 6: pointer byte upper bits ignored
        exp_wr.push_back({8'h03, 8'h77});
        start_c();
        wbyte_chk("t6_addr", 8'h44, 1'b0);
        wbyte_chk("t6_ptr", 8'hF3, 1'b0);
        wbyte_chk("t6_d0", 8'h77, 1'b0);
        stop_c();
        start_c();
        wbyte_chk("t6_waddr", 8'h44, 1'b0);
        wbyte_chk("t6_wptr", 8'hF3, 1'b0);
        start_c();
        wbyte_chk("t6_raddr", 8'h45, 1'b0);
        rbyte_chk("t6_rd3", 1'b1, 8'h77);
        stop_c();

        q_wait();
        chk("final_wr_pending", exp_wr.size(), 0);
      end

      begin : mon
        logic [15:0] exp;
        forever begin
          @(negedge clk);
          if (rst_n && wr_valid_o) begin
            if (exp_wr.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL wr_spurious actual addr=%0h data=%0h required none",
                       wr_addr_o, wr_data_o);
            end else begin
              exp = exp_wr.pop_front();
              chk("wr_addr_data", int'({4'h0, wr_addr_o, wr_data_o}), int'(exp));
            end
          end
          if (sel_o && !sel_prev) sel_rises++;
          sel_prev = sel_o;
        end
      end

      begin : watchdog
        #5ms;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "timeout");
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
